// File: rtl/y86_regs_pkg.sv
// Shared definitions for the Y86-64 register file and its dump sequencer.
// Holds the register index codes, the data and index widths, and the state
// encoding used by reg_dump_seq.
package y86_regs_pkg;

  localparam int DATA_W   = 64;
  localparam int IDX_W    = 4;
  localparam int NUM_REGS = 15;

  // Architectural register indices; RNONE means "no register" and reads 0.
  localparam logic [3:0] RAX   = 4'd0;
  localparam logic [3:0] RCX   = 4'd1;
  localparam logic [3:0] RDX   = 4'd2;
  localparam logic [3:0] RBX   = 4'd3;
  localparam logic [3:0] RSP   = 4'd4;
  localparam logic [3:0] RBP   = 4'd5;
  localparam logic [3:0] RSI   = 4'd6;
  localparam logic [3:0] RDI   = 4'd7;
  localparam logic [3:0] R8    = 4'd8;
  localparam logic [3:0] R9    = 4'd9;
  localparam logic [3:0] R10   = 4'd10;
  localparam logic [3:0] R11   = 4'd11;
  localparam logic [3:0] R12   = 4'd12;
  localparam logic [3:0] R13   = 4'd13;
  localparam logic [3:0] R14   = 4'd14;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SCAN = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } dump_state_t;

endpackage

// File: rtl/dump_out_buf.sv
// Output holding register for the register dump stream.
// Captures one (index, data) beat, presents it on a valid/ready interface
// until accepted, and folds every accepted beat into a running XOR checksum.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   load                  - capture load_idx/load_data and raise out_valid
//   load_idx, load_data   - beat to capture
//   clear                 - zero the checksum (new dump accepted)
//   out_ready             - sink accepts the current beat
//   out_valid, out_idx, out_data - beat presented to the sink
//   checksum              - XOR of all beats accepted since the last clear
//   accepted              - handshake completes this cycle
module dump_out_buf #(
  parameter int DATA_W = y86_regs_pkg::DATA_W,
  parameter int IDX_W  = y86_regs_pkg::IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] checksum,
  output logic              accepted
);

  logic              valid_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] checksum_reg;

  assign accepted  = valid_reg & out_ready;
  assign out_valid = valid_reg;
  assign out_idx   = idx_reg;
  assign out_data  = data_reg;
  assign checksum  = checksum_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      idx_reg      <= '0;
      data_reg     <= '0;
      checksum_reg <= '0;
    end else begin
      // The sequencer never loads while a beat is pending, so load and
      // accept are mutually exclusive in practice.
      if (load) begin
        valid_reg <= 1'b1;
        idx_reg   <= load_idx;
        data_reg  <= load_data;
      end else if (accepted) begin
        valid_reg <= 1'b0;
      end

      if (clear) begin
        checksum_reg <= '0;
      end else if (accepted) begin
        checksum_reg <= checksum_reg ^ data_reg;
      end
    end
  end

endmodule

// File: rtl/reg_dump_seq.sv
// Register file dump sequencer.
// On start, freezes the pipeline via hold_req/hold_ack, walks the masked
// register indices through the srcA read port, and streams each value out
// as an (index, data) beat with a running XOR checksum.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   start, mask    - dump request and register selection (bit i = index i)
//   hold_req/ack   - pipeline freeze handshake; ack means srcA is ours
//   srcA, valA     - register file read port (valA is combinational)
//   out_valid/ready, out_idx, out_data - dump beat stream
//   busy, done     - activity flag and end-of-dump pulse
//   checksum       - XOR of all accepted beats of the current/last dump
module reg_dump_seq #(
  parameter int DATA_W   = y86_regs_pkg::DATA_W,
  parameter int IDX_W    = y86_regs_pkg::IDX_W,
  parameter int NUM_REGS = y86_regs_pkg::NUM_REGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_REGS-1:0] mask,
  output logic                hold_req,
  input  logic                hold_ack,
  output logic [IDX_W-1:0]    srcA,
  input  logic [DATA_W-1:0]   valA,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum
);

  import y86_regs_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] NONE_IDX = {IDX_W{1'b1}};

  dump_state_t         state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [NUM_REGS-1:0] mask_reg, mask_next;

  logic buf_load;
  logic buf_clear;
  logic buf_accepted;
  logic idx_selected;

  assign idx_selected = mask_reg[idx_reg];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      mask_reg  <= mask_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mask_next  = mask_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mask_next = mask;
          if (mask == '0) begin
            state_next = ST_FIN;
          end else begin
            idx_next   = '0;
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (hold_ack) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        // Losing hold_ack only pauses the walk; srcA stays on idx_reg.
        if (hold_ack) begin
          if (idx_selected) begin
            state_next = ST_SEND;
          end else if (idx_reg == LAST_IDX) begin
            state_next = ST_FIN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (buf_accepted) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_FIN;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_SCAN;
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    hold_req  = 1'b0;
    srcA      = NONE_IDX;
    busy      = 1'b1;
    done      = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy      = 1'b0;
        buf_clear = start;
      end
      ST_REQ: begin
        hold_req = 1'b1;
      end
      ST_SCAN: begin
        hold_req = 1'b1;
        srcA     = idx_reg;
        buf_load = hold_ack & idx_selected;
      end
      ST_SEND: begin
        hold_req = 1'b1;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  dump_out_buf #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_buf (
    .clock     (clock),
    .reset     (reset),
    .load      (buf_load),
    .load_idx  (idx_reg),
    .load_data (valA),
    .clear     (buf_clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .checksum  (checksum),
    .accepted  (buf_accepted)
  );

endmodule
